// File: rtl/rat_uart_tx_port.sv
// UART transmitter on the RAT MCU I/O bus: a byte FIFO feeding a serialiser, plus status and interrupt.
// Define UART_TX_PARITY_EN to add an even-parity bit to each frame and set STATUS[5].
module rat_uart_tx_port #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] TX_PORT_ID   = 8'h40,
  parameter logic [7:0] STAT_PORT_ID = 8'h41
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [7:0] OUT_PORT,
  input  logic [7:0] PORT_ID,
  input  logic       IO_STRB,
  output logic [7:0] STATUS,
  output logic       INTV,
  output logic       TX
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_ADV = 1'b1;
`else
  localparam logic PARITY_ADV = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          ie_q, ie_d;
  logic          intv_q, intv_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic       data_wr;
  logic       ctrl_wr;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       push;
  logic       bit_done;
  logic [7:0] head;

  assign data_wr = IO_STRB && (PORT_ID == TX_PORT_ID);
  assign ctrl_wr = IO_STRB && (PORT_ID == STAT_PORT_ID);

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop  = (state_q == S_IDLE) && !fifo_empty;
  assign push = data_wr && (!fifo_full || pop);
  assign head = mem_q[rd_ptr_q[AW-1:0]];

  assign bit_done = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= OUT_PORT;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    ie_d     = ie_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (data_wr && !push) begin
      ovf_d = 1'b1;
    end
    if (ctrl_wr) begin
      if (OUT_PORT[0]) begin
        ovf_d = 1'b0;
      end
      ie_d = OUT_PORT[4];
    end
  end

  // tx_d carries the line level of the state being entered, so TX comes straight from a flop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          sh_d    = head;
          par_d   = ^head;
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_done) begin
          baud_d  = '0;
          state_d = S_DATA;
          tx_d    = sh_q[0];
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_d = '0;
          sh_d   = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[1];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          baud_d  = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_done) begin
          baud_d  = '0;
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign intv_d = ie_q && fifo_empty && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      ie_q     <= 1'b0;
      intv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      ie_q     <= ie_d;
      intv_q   <= intv_d;
    end
  end

  assign TX     = tx_q;
  assign INTV   = intv_q;
  assign STATUS = {2'b00, PARITY_ADV, ie_q, ovf_q, (state_q != S_IDLE), fifo_empty, fifo_full};

endmodule

// File: tb/tb_rat_uart_tx_port.sv
// Self-checking bench for rat_uart_tx_port: scoreboard of written bytes against a TX frame decoder.
module tb_rat_uart_tx_port;

  localparam int CPB = 4;
  localparam logic [7:0] TXP = 8'h40;
  localparam logic [7:0] STP = 8'h41;

  logic       clk = 1'b0;
  logic       RESET;
  logic [7:0] OUT_PORT;
  logic [7:0] PORT_ID;
  logic       IO_STRB;
  logic [7:0] STATUS;
  logic       INTV;
  logic       TX;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  rat_uart_tx_port #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8),
    .TX_PORT_ID   (TXP),
    .STAT_PORT_ID (STP)
  ) dut (
    .clk      (clk),
    .RESET    (RESET),
    .OUT_PORT (OUT_PORT),
    .PORT_ID  (PORT_ID),
    .IO_STRB  (IO_STRB),
    .STATUS   (STATUS),
    .INTV     (INTV),
    .TX       (TX)
  );

  // Called at a negedge; returns at the following negedge with the strobe sampled by exactly one posedge.
  task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
    PORT_ID  = addr;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    @(negedge clk);
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
  endtask

  task automatic wait_status(input logic [7:0] want, input int max, input string name);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      @(negedge clk);
      if (STATUS === want) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: STATUS=%02h never reached required %02h", name, STATUS, want);
    end
  endtask

  task automatic wait_busy_low(input int max, input string name);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < max && !ok; k++) begin
      @(negedge clk);
      if (STATUS[2] === 1'b0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: busy stuck, STATUS=%02h required bit2=0", name, STATUS);
    end
  endtask

  // Frame decoder: samples mid-bit, pops the scoreboard at each complete frame, drops frames cut by reset.
  logic [7:0] mon_got;
  logic       mon_abort;
  logic       mon_frame_ok;
  logic [7:0] mon_exp;
  int         mon_frames = 0;

  task automatic mon_skip(input int n, output logic saw_reset);
    saw_reset = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (RESET !== 1'b1) saw_reset = 1'b1;
    end
  endtask

  initial begin
    logic r;
    forever begin
      @(negedge clk);
      if (RESET === 1'b1 && TX === 1'b0) begin
        mon_abort    = 1'b0;
        mon_frame_ok = 1'b1;
        mon_skip(CPB / 2, r);
        mon_abort = mon_abort | r;
        if (TX !== 1'b0) mon_frame_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          mon_skip(CPB, r);
          mon_abort  = mon_abort | r;
          mon_got[i] = TX;
        end
        mon_skip(CPB, r);
        mon_abort = mon_abort | r;
        if (TX !== 1'b1) mon_frame_ok = 1'b0;
        if (!mon_abort) begin
          mon_frames++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame: got byte %02h, scoreboard required no frame", mon_got);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp || !mon_frame_ok) begin
              errors++;
              $display("FAIL frame: got byte %02h framing_ok=%0b, required %02h framing_ok=1",
                       mon_got, mon_frame_ok, mon_exp);
            end else begin
              $display("frame %0d: byte %02h", mon_frames, mon_got);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    RESET = 1'b0; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
    repeat (3) @(negedge clk);
    checks += 3;
    if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx: TX=%b required 1", TX); end
    if (STATUS !== 8'h02) begin errors++; $display("FAIL reset_status: STATUS=%02h required 02", STATUS); end
    if (INTV !== 1'b0) begin errors++; $display("FAIL reset_intv: INTV=%b required 0", INTV); end
    RESET = 1'b1;
    repeat (3) @(negedge clk);
    checks += 3;
    if (TX !== 1'b1) begin errors++; $display("FAIL post_reset_tx: TX=%b required 1", TX); end
    if (STATUS !== 8'h02) begin errors++; $display("FAIL post_reset_status: STATUS=%02h required 02", STATUS); end
    if (INTV !== 1'b0) begin errors++; $display("FAIL post_reset_intv: INTV=%b required 0", INTV); end
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    exp_q.push_back(8'hA5);
    io_write(TXP, 8'hA5);
    checks++;
    if (TX !== 1'b1) begin errors++; $display("FAIL single_prestart: TX=%b required 1", TX); end
    for (int j = 0; j < 10 * CPB; j++) begin
      @(negedge clk);
      checks += 2;
      if (TX !== frame[j / CPB]) begin
        errors++; $display("FAIL single_tx[%0d]: TX=%b required %b", j, TX, frame[j / CPB]);
      end
      if (STATUS[2] !== 1'b1) begin
        errors++; $display("FAIL single_busy[%0d]: STATUS=%02h required bit2=1", j, STATUS);
      end
    end
    @(negedge clk);
    checks += 2;
    if (STATUS !== 8'h02) begin errors++; $display("FAIL single_done_status: STATUS=%02h required 02", STATUS); end
    if (TX !== 1'b1) begin errors++; $display("FAIL single_done_tx: TX=%b required 1", TX); end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    for (int i = 0; i < 10; i++) begin
      b = 8'hC0 + 8'(i);
      if (i < 9) exp_q.push_back(b);
      io_write(TXP, b);
    end
    checks += 2;
    if (STATUS[3] !== 1'b1) begin errors++; $display("FAIL ovf_set: STATUS=%02h required bit3=1", STATUS); end
    if (STATUS[0] !== 1'b1) begin errors++; $display("FAIL ovf_full: STATUS=%02h required bit0=1", STATUS); end
    io_write(STP, 8'h01);
    checks++;
    if (STATUS[3] !== 1'b0) begin errors++; $display("FAIL ovf_clear: STATUS=%02h required bit3=0", STATUS); end
    wait_status(8'h02, 800, "ovf_drain");
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_count: %0d bytes unsent, required 0", exp_q.size()); end
  endtask

  task automatic test_full_pop();
    logic [7:0] b;
    for (int i = 0; i < 9; i++) begin
      b = 8'h50 + 8'(i);
      exp_q.push_back(b);
      io_write(TXP, b);
    end
    checks += 2;
    if (STATUS[0] !== 1'b1) begin errors++; $display("FAIL fullpop_full: STATUS=%02h required bit0=1", STATUS); end
    if (STATUS[3] !== 1'b0) begin errors++; $display("FAIL fullpop_noovf: STATUS=%02h required bit3=0", STATUS); end
    wait_busy_low(100, "fullpop_wait_idle");
    exp_q.push_back(8'h5F);
    io_write(TXP, 8'h5F);
    checks += 3;
    if (STATUS[3] !== 1'b0) begin errors++; $display("FAIL fullpop_ovf: STATUS=%02h required bit3=0", STATUS); end
    if (STATUS[0] !== 1'b1) begin errors++; $display("FAIL fullpop_still_full: STATUS=%02h required bit0=1", STATUS); end
    if (STATUS[2] !== 1'b1) begin errors++; $display("FAIL fullpop_busy: STATUS=%02h required bit2=1", STATUS); end
    wait_status(8'h02, 800, "fullpop_drain");
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL fullpop_count: %0d bytes unsent, required 0", exp_q.size()); end
  endtask

  task automatic test_interrupt();
    io_write(STP, 8'h10);
    @(negedge clk);
    checks += 2;
    if (INTV !== 1'b1) begin errors++; $display("FAIL intv_assert: INTV=%b required 1", INTV); end
    if (STATUS !== 8'h12) begin errors++; $display("FAIL intv_status: STATUS=%02h required 12", STATUS); end
    exp_q.push_back(8'h33);
    io_write(TXP, 8'h33);
    @(negedge clk);
    checks++;
    if (INTV !== 1'b0) begin errors++; $display("FAIL intv_drop: INTV=%b required 0", INTV); end
    wait_busy_low(100, "intv_wait_idle");
    checks++;
    if (INTV !== 1'b0) begin errors++; $display("FAIL intv_at_stop_end: INTV=%b required 0", INTV); end
    @(negedge clk);
    checks++;
    if (INTV !== 1'b1) begin errors++; $display("FAIL intv_reassert: INTV=%b required 1", INTV); end
    io_write(STP, 8'h00);
    @(negedge clk);
    checks++;
    if (INTV !== 1'b0) begin errors++; $display("FAIL intv_ie_clear: INTV=%b required 0", INTV); end
  endtask

  task automatic test_reset_midframe();
    logic saw_low;
    io_write(TXP, 8'hFF);
    io_write(TXP, 8'h11);
    io_write(TXP, 8'h22);
    io_write(TXP, 8'h33);
    repeat (15) @(negedge clk);
    checks++;
    if (STATUS !== 8'h04) begin errors++; $display("FAIL midframe_pre: STATUS=%02h required 04", STATUS); end
    #2 RESET = 1'b0;
    #1;
    checks += 3;
    if (TX !== 1'b1) begin errors++; $display("FAIL midframe_tx: TX=%b required 1", TX); end
    if (STATUS !== 8'h02) begin errors++; $display("FAIL midframe_status: STATUS=%02h required 02", STATUS); end
    if (INTV !== 1'b0) begin errors++; $display("FAIL midframe_intv: INTV=%b required 0", INTV); end
    repeat (2) @(negedge clk);
    RESET = 1'b1;
    @(negedge clk);
    checks++;
    if (STATUS !== 8'h02) begin errors++; $display("FAIL midframe_release: STATUS=%02h required 02", STATUS); end
    saw_low = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (TX !== 1'b1) saw_low = 1'b1;
    end
    checks++;
    if (saw_low) begin errors++; $display("FAIL midframe_quiet: TX went low after reset, required idle high"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_overflow();
    test_full_pop();
    test_interrupt();
    test_reset_midframe();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: %0d left, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
